// File: rtl/alu_flag_unit_pkg.sv
// Shared definitions for the ALU flag unit: ALUOp and branch-condition
// encodings, FSM state type and status-register bit positions.
package alu_flag_unit_pkg;

    localparam logic [3:0] ALU_NOP   = 4'b0000;
    localparam logic [3:0] ALU_ADDU  = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_SUBU  = 4'b0011;
    localparam logic [3:0] ALU_SUB   = 4'b0100;
    localparam logic [3:0] ALU_AND   = 4'b0101;
    localparam logic [3:0] ALU_OR    = 4'b0110;
    localparam logic [3:0] ALU_NOR   = 4'b0111;
    localparam logic [3:0] ALU_XOR   = 4'b1000;
    localparam logic [3:0] ALU_SLT   = 4'b1001;
    localparam logic [3:0] ALU_SLTU  = 4'b1010;
    localparam logic [3:0] ALU_SPADD = 4'b1111;

    localparam logic [2:0] BR_EQ  = 3'd0;
    localparam logic [2:0] BR_NE  = 3'd1;
    localparam logic [2:0] BR_LTZ = 3'd2;
    localparam logic [2:0] BR_GEZ = 3'd3;
    localparam logic [2:0] BR_GTZ = 3'd4;
    localparam logic [2:0] BR_LEZ = 3'd5;
    localparam logic [2:0] BR_CS  = 3'd6;
    localparam logic [2:0] BR_CC  = 3'd7;

    localparam int ST_ZERO  = 0;
    localparam int ST_CARRY = 1;
    localparam int ST_NEG   = 2;
    localparam int ST_OVF   = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_PEND = 1'b1
    } state_t;

    // Only the signed arithmetic ops raise an overflow exception
    function automatic logic isTrapOp(input logic [3:0] op);
        return (op == ALU_ADD) || (op == ALU_SUB) || (op == ALU_SPADD);
    endfunction

endpackage

// File: rtl/alu_flag_unit_cond_eval.sv
// Combinational branch-condition evaluator: decides taken/not-taken
// from the (possibly forwarded) status flags and a 3-bit condition code.
module flag_cond_eval
    import alu_flag_unit_pkg::*;
(
    input  logic [3:0] status_i,
    input  logic [2:0] br_cond_i,
    output logic       taken_o
);

    logic zeroF;
    logic carryF;
    logic negF;
    logic unused_ovf;

    assign zeroF      = status_i[ST_ZERO];
    assign carryF     = status_i[ST_CARRY];
    assign negF       = status_i[ST_NEG];
    assign unused_ovf = status_i[ST_OVF];

    // Map each condition code onto its flag expression
    always_comb begin
        taken_o = 1'b0;
        case (br_cond_i)
            BR_EQ:   taken_o = zeroF;
            BR_NE:   taken_o = ~zeroF;
            BR_LTZ:  taken_o = negF;
            BR_GEZ:  taken_o = ~negF;
            BR_GTZ:  taken_o = ~negF & ~zeroF;
            BR_LEZ:  taken_o = negF | zeroF;
            BR_CS:   taken_o = carryF;
            BR_CC:   taken_o = ~carryF;
            default: taken_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu_flag_unit.sv
// ALU flag unit: status register with sticky overflow, one-cycle branch
// query port with same-cycle flag forwarding, and an optional overflow
// trap FSM enabled by defining ALU_FLAG_OVF_TRAP_EN.
module alu_flag_unit
    import alu_flag_unit_pkg::*;
#(
    parameter logic [4:0] EXC_OV_CODE = 5'd12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_valid,
    input  logic [3:0]  alu_op,
    input  logic        alu_zero,
    input  logic        alu_carry,
    input  logic        alu_neg,
    input  logic        alu_ovf,
    input  logic        flag_we,
    input  logic [31:0] ex_pc,
    output logic [31:0] exc_epc,
    input  logic        br_valid,
    input  logic [2:0]  br_cond,
    output logic        br_ready,
    output logic        br_resp_valid,
    output logic        br_taken,
    output logic        exc_req,
    output logic [4:0]  exc_code,
    input  logic        exc_ack,
    output logic        stall,
    output logic [3:0]  status
);

    state_t      state_q, state_d;
    logic [3:0]  status_q, status_d;
    logic [31:0] epc_q, epc_d;
    logic [4:0]  code_q, code_d;
    logic        resp_q, resp_d;
    logic        taken_q, taken_d;

    logic        isIdle;
    logic        flagWrite;
    logic        brAccept;
    logic        trapEnter;
    logic        ackPend;
    logic        condTaken;
    logic [3:0]  statusWr;
    logic [3:0]  statusFwd;

    assign isIdle    = (state_q == ST_IDLE);
    assign flagWrite = alu_valid & flag_we & isIdle;
    assign statusWr  = {status_q[ST_OVF] | alu_ovf, alu_neg, alu_carry, alu_zero};
    assign statusFwd = flagWrite ? statusWr : status_q;
    assign br_ready  = isIdle & ~resp_q;
    assign brAccept  = br_valid & br_ready;

`ifdef ALU_FLAG_OVF_TRAP_EN
    assign trapEnter = isIdle & alu_valid & alu_ovf & isTrapOp(alu_op);
    assign ackPend   = (state_q == ST_PEND) & exc_ack;
`else
    logic unused_trap_inputs;
    assign trapEnter          = 1'b0;
    assign ackPend            = 1'b0;
    assign unused_trap_inputs = ^{alu_op, exc_ack};
`endif

    flag_cond_eval u_cond (
        .status_i  (statusFwd),
        .br_cond_i (br_cond),
        .taken_o   (condTaken)
    );

    // Next-state for the FSM, status register and branch response
    always_comb begin
        state_d  = state_q;
        status_d = status_q;
        epc_d    = epc_q;
        code_d   = code_q;
        resp_d   = brAccept;
        taken_d  = brAccept ? condTaken : taken_q;
        if (flagWrite) begin
            status_d = statusWr;
        end
        if (trapEnter) begin
            state_d = ST_PEND;
            epc_d   = ex_pc;
            code_d  = EXC_OV_CODE;
        end
        if (ackPend) begin
            state_d          = ST_IDLE;
            status_d[ST_OVF] = 1'b0;
        end
    end

    // All state, with reset taking priority over every input
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            status_q <= 4'b0000;
            epc_q    <= 32'h0000_0000;
            code_q   <= 5'd0;
            resp_q   <= 1'b0;
            taken_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            status_q <= status_d;
            epc_q    <= epc_d;
            code_q   <= code_d;
            resp_q   <= resp_d;
            taken_q  <= taken_d;
        end
    end

    assign exc_req       = (state_q == ST_PEND);
    assign stall         = (state_q == ST_PEND);
    assign exc_code      = code_q;
    assign exc_epc       = epc_q;
    assign status        = status_q;
    assign br_resp_valid = resp_q;
    assign br_taken      = taken_q;

endmodule

// File: tb/tb_alu_flag_unit.sv
// Self-checking bench for alu_flag_unit: directed scenarios followed by
// randomized traffic compared against a behavioural model of the flags,
// branch queries and overflow trap.
module tb_alu_flag_unit;
    import alu_flag_unit_pkg::*;

    logic        clk;
    logic        rst;
    logic        alu_valid;
    logic [3:0]  alu_op;
    logic        alu_zero;
    logic        alu_carry;
    logic        alu_neg;
    logic        alu_ovf;
    logic        flag_we;
    logic [31:0] ex_pc;
    logic [31:0] exc_epc;
    logic        br_valid;
    logic [2:0]  br_cond;
    logic        br_ready;
    logic        br_resp_valid;
    logic        br_taken;
    logic        exc_req;
    logic [4:0]  exc_code;
    logic        exc_ack;
    logic        stall;
    logic [3:0]  status;

    int checks = 0;
    int errors = 0;

`ifdef ALU_FLAG_OVF_TRAP_EN
    localparam bit TRAP_ON = 1'b1;
`else
    localparam bit TRAP_ON = 1'b0;
`endif

    // Reference model state
    bit          mPend;
    bit          mZero, mCarry, mNeg, mOvf;
    bit          mResp, mTaken;
    logic [31:0] mEpc;
    logic [4:0]  mCode;

    alu_flag_unit #(.EXC_OV_CODE(5'd12)) dut (
        .clk           (clk),
        .rst           (rst),
        .alu_valid     (alu_valid),
        .alu_op        (alu_op),
        .alu_zero      (alu_zero),
        .alu_carry     (alu_carry),
        .alu_neg       (alu_neg),
        .alu_ovf       (alu_ovf),
        .flag_we       (flag_we),
        .ex_pc         (ex_pc),
        .exc_epc       (exc_epc),
        .br_valid      (br_valid),
        .br_cond       (br_cond),
        .br_ready      (br_ready),
        .br_resp_valid (br_resp_valid),
        .br_taken      (br_taken),
        .exc_req       (exc_req),
        .exc_code      (exc_code),
        .exc_ack       (exc_ack),
        .stall         (stall),
        .status        (status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic bit condHolds(input logic [2:0] cond, input bit z, input bit n, input bit c);
        case (cond)
            BR_EQ:   return z;
            BR_NE:   return !z;
            BR_LTZ:  return n;
            BR_GEZ:  return !n;
            BR_GTZ:  return !n && !z;
            BR_LEZ:  return n || z;
            BR_CS:   return c;
            default: return !c;
        endcase
    endfunction

    function automatic bit opTraps(input logic [3:0] op);
        return (op == ALU_ADD) || (op == ALU_SUB) || (op == ALU_SPADD);
    endfunction

    task automatic compareAll();
        checkOutput("status", {28'd0, status}, {28'd0, mOvf, mNeg, mCarry, mZero});
        checkOutput("br_resp_valid", {31'd0, br_resp_valid}, {31'd0, mResp});
        checkOutput("br_taken", {31'd0, br_taken}, {31'd0, mTaken});
        checkOutput("br_ready", {31'd0, br_ready}, {31'd0, !mPend && !mResp});
        checkOutput("exc_req", {31'd0, exc_req}, {31'd0, mPend});
        checkOutput("stall", {31'd0, stall}, {31'd0, mPend});
        checkOutput("exc_code", {27'd0, exc_code}, {27'd0, mCode});
        checkOutput("exc_epc", exc_epc, mEpc);
    endtask

    // Drive one cycle of inputs, advance the model, clock, then compare
    task automatic applyStimulus(input bit r, input bit av, input logic [3:0] op,
                                 input bit z, input bit c, input bit n, input bit o,
                                 input bit we, input logic [31:0] pc,
                                 input bit bv, input logic [2:0] cond, input bit ack);
        bit idle, ready, wr, z2, n2, c2;
        rst = r; alu_valid = av; alu_op = op; alu_zero = z; alu_carry = c;
        alu_neg = n; alu_ovf = o; flag_we = we; ex_pc = pc;
        br_valid = bv; br_cond = cond; exc_ack = ack;
        if (r) begin
            mPend = 0; mZero = 0; mCarry = 0; mNeg = 0; mOvf = 0;
            mResp = 0; mTaken = 0; mEpc = 32'd0; mCode = 5'd0;
        end else begin
            idle  = !mPend;
            ready = idle && !mResp;
            wr    = idle && av && we;
            z2 = wr ? z : mZero;
            n2 = wr ? n : mNeg;
            c2 = wr ? c : mCarry;
            if (bv && ready) mTaken = condHolds(cond, z2, n2, c2);
            mResp = bv && ready;
            if (idle) begin
                if (wr) begin
                    mZero = z; mCarry = c; mNeg = n; mOvf = mOvf || o;
                end
                if (TRAP_ON && av && o && opTraps(op)) begin
                    mPend = 1; mEpc = pc; mCode = 5'd12;
                end
            end else if (ack) begin
                mPend = 0; mOvf = 0;
            end
        end
        @(posedge clk);
        @(negedge clk);
        compareAll();
    endtask

    task automatic idleCycle();
        applyStimulus(0, 0, ALU_NOP, 0, 0, 0, 0, 0, 32'd0, 0, BR_EQ, 0);
    endtask

    task automatic resetCycle();
        applyStimulus(1, 0, ALU_NOP, 0, 0, 0, 0, 0, 32'd0, 0, BR_EQ, 0);
    endtask

    logic [3:0] opList [12];

    initial begin
        opList = '{ALU_NOP, ALU_ADDU, ALU_ADD, ALU_SUBU, ALU_SUB, ALU_AND,
                   ALU_OR, ALU_NOR, ALU_XOR, ALU_SLT, ALU_SLTU, ALU_SPADD};

        resetCycle();
        checkOutput("reset_status", {28'd0, status}, 32'd0);
        checkOutput("reset_ready", {31'd0, br_ready}, 32'd1);
        checkOutput("reset_exc_req", {31'd0, exc_req}, 32'd0);

        // SUB writes zero, then EQ / NE queries
        applyStimulus(0, 1, ALU_SUB, 1, 0, 0, 0, 1, 32'h100, 0, BR_EQ, 0);
        applyStimulus(0, 0, ALU_NOP, 0, 0, 0, 0, 0, 32'd0, 1, BR_EQ, 0);
        checkOutput("eq_resp", {31'd0, br_resp_valid}, 32'd1);
        checkOutput("eq_taken", {31'd0, br_taken}, 32'd1);
        idleCycle();
        checkOutput("eq_resp_drop", {31'd0, br_resp_valid}, 32'd0);
        applyStimulus(0, 0, ALU_NOP, 0, 0, 0, 0, 0, 32'd0, 1, BR_NE, 0);
        checkOutput("ne_taken", {31'd0, br_taken}, 32'd0);
        checkOutput("ne_resp", {31'd0, br_resp_valid}, 32'd1);

        // Forwarding: same-cycle neg write with LTZ query
        idleCycle();
        applyStimulus(0, 1, ALU_ADDU, 0, 0, 1, 0, 1, 32'h104, 1, BR_LTZ, 0);
        checkOutput("fwd_ltz_taken", {31'd0, br_taken}, 32'd1);
        checkOutput("fwd_status", {28'd0, status}, 32'd4);

        // ADDU overflow is sticky but never traps; reset clears it
        applyStimulus(0, 1, ALU_ADDU, 0, 0, 0, 1, 1, 32'h108, 0, BR_EQ, 0);
        checkOutput("addu_no_trap", {31'd0, exc_req}, 32'd0);
        checkOutput("addu_ovf_sticky", {31'd0, status[3]}, 32'd1);
        applyStimulus(0, 1, ALU_AND, 1, 0, 0, 0, 1, 32'h10c, 0, BR_EQ, 0);
        checkOutput("ovf_still_sticky", {31'd0, status[3]}, 32'd1);
        resetCycle();
        checkOutput("rst_clears_status", {28'd0, status}, 32'd0);

`ifdef ALU_FLAG_OVF_TRAP_EN
        applyStimulus(0, 1, ALU_ADD, 0, 0, 0, 1, 0, 32'h0040_0020, 0, BR_EQ, 0);
        checkOutput("trap_req", {31'd0, exc_req}, 32'd1);
        checkOutput("trap_stall", {31'd0, stall}, 32'd1);
        checkOutput("trap_code", {27'd0, exc_code}, 32'd12);
        checkOutput("trap_epc", exc_epc, 32'h0040_0020);
        checkOutput("trap_ready", {31'd0, br_ready}, 32'd0);
        applyStimulus(0, 1, ALU_ADD, 0, 0, 0, 1, 1, 32'h0040_0024, 1, BR_EQ, 1);
        checkOutput("ack_no_retrap", {31'd0, exc_req}, 32'd0);
        checkOutput("ack_no_resp", {31'd0, br_resp_valid}, 32'd0);
        applyStimulus(0, 1, ALU_SUB, 0, 0, 0, 1, 1, 32'h0040_0030, 1, BR_NE, 0);
        checkOutput("trap_with_resp", {31'd0, br_resp_valid}, 32'd1);
        applyStimulus(1, 0, ALU_NOP, 0, 0, 0, 0, 0, 32'd0, 0, BR_EQ, 1);
        checkOutput("rst_pend_req", {31'd0, exc_req}, 32'd0);
        checkOutput("rst_pend_epc", exc_epc, 32'd0);
        checkOutput("rst_pend_code", {27'd0, exc_code}, 32'd0);
`else
        applyStimulus(0, 1, ALU_SUB, 0, 0, 0, 1, 1, 32'h0040_0020, 0, BR_EQ, 0);
        checkOutput("notrap_req", {31'd0, exc_req}, 32'd0);
        checkOutput("notrap_ovf", {31'd0, status[3]}, 32'd1);
        checkOutput("notrap_ready", {31'd0, br_ready}, 32'd1);
        applyStimulus(0, 0, ALU_NOP, 0, 0, 0, 0, 0, 32'd0, 0, BR_EQ, 1);
        checkOutput("notrap_ack_keeps_ovf", {31'd0, status[3]}, 32'd1);
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            applyStimulus($urandom_range(0, 39) == 0,
                          $urandom_range(0, 1) == 1,
                          opList[$urandom_range(0, 11)],
                          $urandom_range(0, 1) == 1,
                          $urandom_range(0, 1) == 1,
                          $urandom_range(0, 1) == 1,
                          $urandom_range(0, 3) == 0,
                          $urandom_range(0, 1) == 1,
                          $urandom,
                          $urandom_range(0, 1) == 1,
                          3'($urandom_range(0, 7)),
                          $urandom_range(0, 2) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_flag_unit.md
ALU_FLAG_UNIT -- requirements
Module: alu_flag_unit

Interface
REQ-001 SHALL have parameter EXC_OV_CODE, default 5'd12, exception code driven on arithmetic overflow.
REQ-002 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have ports alu_valid in 1 (EX result valid) and alu_op in 4 (ALUOp of that result).
REQ-005 SHALL have ports alu_zero, alu_carry, alu_neg, alu_ovf  in  1 each  ALU flags.
REQ-006 SHALL have port flag_we  in  1  status-register write enable, qualified by alu_valid.
REQ-007 SHALL have ports ex_pc  in  32 (PC of the EX instruction) and exc_epc  out  32 (captured PC).
REQ-008 SHALL have ports br_valid in 1, br_cond in 3, br_ready out 1 for the branch-query request.
REQ-009 SHALL have ports br_resp_valid out 1 and br_taken out 1 for the branch response.
REQ-010 SHALL have ports exc_req out 1, exc_code out 5, exc_ack in 1, stall out 1, status out 4 ({ovf,neg,carry,zero}).

Function
REQ-011 SHALL update status on alu_valid & flag_we & state IDLE; else hold.
REQ-012 SHALL set status[3] (ovf) sticky: set by any written overflow, cleared only by reset or exc_ack.
REQ-013 SHALL accept a branch query when br_valid & br_ready; br_ready = (state == IDLE) & ~br_resp_valid.
REQ-014 SHALL assert br_resp_valid for exactly one cycle, the cycle after acceptance (latency 1).
REQ-015 SHALL evaluate br_cond against status forwarded from a same-cycle write: 0 EQ(zero), 1 NE(~zero), 2 LTZ(neg), 3 GEZ(~neg), 4 GTZ(~neg&~zero), 5 LEZ(neg|zero), 6 CS(carry), 7 CC(~carry).
REQ-016 SHALL hold br_taken registered until the next response; value meaningful only with br_resp_valid.
REQ-017 SHALL implement FSM IDLE/PEND: IDLE->PEND when alu_valid & alu_ovf & alu_op in {ALU_ADD, ALU_SUB, ALU_SPADD}; PEND->IDLE on exc_ack.
REQ-018 SHALL on IDLE->PEND capture ex_pc into exc_epc and drive exc_code = EXC_OV_CODE.
REQ-019 SHALL drive exc_req = stall = (state == PEND), registered.
REQ-020 SHALL ignore alu_valid, flag_we, br_valid during PEND and on the ack cycle itself.
REQ-021 SHALL ignore overflow from ADDU/SUBU/logic ops for trapping (status still written).
REQ-022 SHALL ignore exc_ack in IDLE (no state or flag change).
REQ-023 SHALL complete an accepted query's response even if PEND is entered the same cycle.

Reset
REQ-024 SHALL on rst: state IDLE, status 0, exc_epc 0, exc_code 0, exc_req 0, stall 0, br_resp_valid 0, br_taken 0.
REQ-025 SHALL give rst priority over all inputs, including exc_ack and a pending query response (dropped).

Configuration
REQ-026 SHALL honour macro ALU_FLAG_OVF_TRAP_EN: defined -> REQ-017..REQ-020 active.
REQ-027 SHALL, without ALU_FLAG_OVF_TRAP_EN, hold state IDLE, exc_req/stall/exc_code/exc_epc at 0; sticky ovf cleared by reset only.

Structure
REQ-028 SHALL take ALU_ADD/ALU_SUB from ctrl_encode_def.v; add ALU_SPADD (4'b1111) and BR_EQ..BR_CC codes there.
REQ-029 SHALL place condition evaluation in combinational sub-module flag_cond_eval (status, br_cond -> taken).

Verification
REQ-030 SUB with zero=1, flag_we=1, then query EQ -> next cycle br_resp_valid=1, br_taken=1; NE -> 0.
REQ-031 Same-cycle write neg=1 and query LTZ -> br_taken=1 one cycle later (forwarding).
REQ-032 ADD ovf=1, ex_pc=0x00400020 -> next cycle exc_req=1, stall=1, exc_code=12, exc_epc=0x00400020; br_ready=0.
REQ-033 ADDU ovf=1 -> exc_req stays 0, status[3]=1; after rst status=0.
REQ-034 PEND, exc_ack with simultaneous ADD ovf -> IDLE, no re-trap; rst during PEND -> all outputs per REQ-024.
REQ-035 Build without ALU_FLAG_OVF_TRAP_EN, SUB ovf=1 -> exc_req=0, status[3]=1, br_ready remains 1.
